// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_pkg: types and helpers shared by the FIFO write arbiter.
//   arb_state_e      - arbiter ownership state (IDLE / OWN)
//   FIFO_DATA_WIDTH  - default entry width, matches the fifo block
//   rr_pick()        - first set bit of valid[], searching from start and
//                      wrapping modulo n (n need not be a power of two)
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 2;
  localparam int MAX_REQ         = 8;  // largest supported NUM_REQ
  localparam int MAX_REQ_W       = 3;  // index width for MAX_REQ

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Returns start when nothing is valid; callers gate with an any-valid flag.
  function automatic logic [MAX_REQ_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   valid,
    input logic [MAX_REQ_W-1:0] start,
    input int                   n
  );
    logic [MAX_REQ_W-1:0] idx;
    logic [3:0]           j;
    logic                 found;
    idx   = start;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        // start < n and k < n, so one subtraction is a full modulo
        j = {1'b0, start} + 4'(k);
        if (j >= 4'(n)) j = j - 4'(n);
        if (!found && valid[j[MAX_REQ_W-1:0]]) begin
          idx   = j[MAX_REQ_W-1:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake plus the fifo write port, bundled for the arbiter.
//   master: arbiter view (takes requests and fifo_full, drives grant/write)
//   slave : environment view (producers + fifo)
interface fifo_wr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic [ID_WIDTH-1:0]           grant_id;
  logic [15:0]                   xfer_cnt;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_data, grant_id, xfer_cnt
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_data, grant_id, xfer_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// rr_pick_comb: combinational rotate-priority encoder.
//   valid - request vector
//   start - index where the search begins (wraps modulo NUM_REQ)
//   idx   - first valid index at or after start
//   any   - at least one request is valid
module rr_pick_comb
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      start,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [MAX_REQ-1:0]   valid_ext;
  logic [MAX_REQ_W-1:0] start_ext;

  assign valid_ext = MAX_REQ'(valid);
  assign start_ext = MAX_REQ_W'(start);
  assign idx       = IW'(rr_pick(valid_ext, start_ext, NUM_REQ));
  assign any       = |valid;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the fifo write port between
// NUM_REQ valid/ready producers, with a burst limit per owner.
//   clk, rst       - clock, synchronous active-high reset
//   bus.req_valid  - per-producer request
//   bus.req_data   - flat producer data, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bus.req_ready  - one-hot (or zero) accept strobe
//   bus.fifo_full  - from fifo.full
//   bus.fifo_wr    - to fifo.wr
//   bus.fifo_data  - to fifo.data_in
//   bus.grant_id   - producer owning the current write (valid with fifo_wr)
//   bus.xfer_cnt   - accepted writes, wraps at 2^16
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [3:0]          burst_q, burst_d;
  logic [15:0]         xfer_q, xfer_d;

  logic [ID_WIDTH-1:0] start_idx;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                any_valid;
  logic                keep_owner;
  logic [ID_WIDTH-1:0] grant;
  logic                xfer;

  // Rotation resumes just after the last granted producer.
  assign start_idx = (last_q == ID_WIDTH'(NUM_REQ-1)) ? '0 : last_q + 1'b1;

  rr_pick_comb #(.NUM_REQ(NUM_REQ), .IW(ID_WIDTH)) u_pick (
    .valid (bus.req_valid),
    .start (start_idx),
    .idx   (pick_idx),
    .any   (any_valid)
  );

  // Owner stays while it still requests and has burst budget left. When the
  // budget is spent the search from owner+1 wraps back to the owner itself if
  // nobody else requests, so a lone requester never sees an idle bubble.
  assign keep_owner = (state_q == OWN) && bus.req_valid[last_q] &&
                      (burst_q < 4'(MAX_BURST));
  assign grant      = keep_owner ? last_q : pick_idx;
  assign xfer       = any_valid && !bus.fifo_full && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ID_WIDTH'(NUM_REQ-1);
      burst_q <= 4'd0;
      xfer_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      xfer_q  <= xfer_d;
    end
  end

  // Next state. A full fifo with pending requests falls through both
  // branches, so ownership and burst count are frozen until space returns.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    xfer_d  = xfer_q;
    if (xfer) begin
      state_d = OWN;
      xfer_d  = xfer_q + 16'd1;
      if (grant == last_q) begin
        burst_d = (burst_q >= 4'(MAX_BURST)) ? 4'(MAX_BURST) : burst_q + 4'd1;
      end else begin
        last_d  = grant;
        burst_d = 4'd1;
      end
    end else if (!any_valid) begin
      // last_q is kept so the rotation position survives idle periods
      state_d = IDLE;
      burst_d = 4'd0;
    end
  end

  // Outputs
  always_comb begin
    bus.fifo_wr   = xfer;
    bus.grant_id  = grant;
    bus.xfer_cnt  = xfer_q;
    bus.req_ready = '0;
    bus.fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_WIDTH'(i)) begin
        bus.req_ready[i] = xfer;
        bus.fifo_data    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 2;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [7:0]  data;
    logic        full;
    logic        exp_wr;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_gid;
    logic [1:0]  exp_dat;
    logic [15:0] exp_xfer;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] tb_valid = '0;
  logic [7:0] tb_data  = '0;
  logic full_drv = 1'b0;
  logic rd_en    = 1'b0;
  logic model_en = 1'b0;
  logic e2e_en   = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // bench fifo model (depth 16) and end-to-end producer state
  logic [1:0] fq[$];
  logic [1:0] exp_log[$];
  int fcnt = 0;
  int popped = 0;
  logic [1:0] pdata[NR][16];
  int pidx[NR];
  logic [3:0] e2e_valid;
  logic [7:0] e2e_data;
  logic snap_wr = 1'b0, snap_rd = 1'b0;
  logic [1:0] snap_d = '0, snap_g = '0;

  vec_t tv[$];

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.req_valid = e2e_en ? e2e_valid : tb_valid;
  assign bus.req_data  = e2e_en ? e2e_data  : tb_data;
  assign bus.fifo_full = full_drv | (model_en && fcnt == 16);

  always_comb begin
    e2e_valid = '0;
    e2e_data  = '0;
    for (int i = 0; i < NR; i++) begin
      if (pidx[i] < 16) begin
        e2e_valid[i]       = 1'b1;
        e2e_data[i*DW +: DW] = pdata[i][pidx[i]];
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // sample away from the active edge; writes land at the following posedge
  always @(negedge clk) begin
    snap_wr = bus.fifo_wr;
    snap_d  = bus.fifo_data;
    snap_g  = bus.grant_id;
    snap_rd = rd_en || (e2e_en && $urandom_range(0, 3) != 0);
    if (e2e_en && bus.fifo_wr) begin
      chk("e2e_ready", n_chk, 32'(bus.req_ready), 32'(4'(1) << bus.grant_id));
      if (pidx[bus.grant_id] < 16) begin
        chk("e2e_data", n_chk, 32'(bus.fifo_data),
            32'(pdata[bus.grant_id][pidx[bus.grant_id]]));
        exp_log.push_back(pdata[bus.grant_id][pidx[bus.grant_id]]);
      end else begin
        chk("e2e_dup_grant", int'(bus.grant_id), 32'(pidx[bus.grant_id]), 32'd15);
      end
    end
  end

  always @(posedge clk) begin
    logic [1:0] v, e;
    if (rst) begin
      fq.delete();
      exp_log.delete();
      popped <= 0;
      for (int i = 0; i < NR; i++) pidx[i] <= 0;
    end else begin
      if (snap_rd && fq.size() > 0) begin
        v = fq.pop_front();
        if (e2e_en) begin
          e = (exp_log.size() > 0) ? exp_log.pop_front() : ~v;
          chk("e2e_order", popped, 32'(v), 32'(e));
          popped <= popped + 1;
        end
      end
      if (snap_wr && model_en) fq.push_back(snap_d);
      if (snap_wr && e2e_en) pidx[snap_g] <= pidx[snap_g] + 1;
    end
    fcnt <= fq.size();
  end

  task automatic drive(input logic r, input logic [3:0] v, input logic [7:0] d,
                       input logic f, input logic rd);
    @(posedge clk);
    #1;
    rst = r; tb_valid = v; tb_data = d; full_drv = f; rd_en = rd;
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [7:0] d,
                     input logic f, input logic w, input logic [3:0] rdy,
                     input logic [1:0] gid, input logic [1:0] dat,
                     input logic [15:0] x);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.full = f; t.exp_wr = w;
    t.exp_ready = rdy; t.exp_gid = gid; t.exp_dat = dat; t.exp_xfer = x;
    tv.push_back(t);
  endtask

  initial begin
    int cyc;
    // ---- vector table: slot i of 8'hE4 carries value i ----
    // single producer, data 3
    add(1, 4'b0001, 8'h03, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 8'h03, 0, 1, 4'b0001, 0, 3, 0);
    add(0, 4'b0001, 8'h03, 0, 1, 4'b0001, 0, 3, 1);
    add(0, 4'b0001, 8'h03, 0, 1, 4'b0001, 0, 3, 2);
    add(0, 4'b0000, 8'h03, 0, 0, 4'b0000, 0, 0, 3);
    // all requesting: bursts of 4
    add(1, 4'b1111, 8'hE4, 0, 0, 4'b0000, 0, 0, 3);
    for (int k = 0; k < 12; k++)
      add(0, 4'b1111, 8'hE4, 0, 1, 4'(1) << (k/4), 2'(k/4), 2'(k/4), 16'(k));
    // lone requester beyond the burst limit: no bubble
    add(1, 4'b0100, 8'hE4, 0, 0, 4'b0000, 0, 0, 12);
    for (int k = 0; k < 10; k++)
      add(0, 4'b0100, 8'hE4, 0, 1, 4'b0100, 2, 2, 16'(k));
    // saturated owner 2 yields; search wraps 3,0,1
    add(0, 4'b0110, 8'hE4, 0, 1, 4'b0010, 1, 1, 10);
    add(0, 4'b0110, 8'hE4, 0, 1, 4'b0010, 1, 1, 11);
    add(0, 4'b0110, 8'hE4, 1, 0, 4'b0000, 0, 0, 12);
    add(0, 4'b0110, 8'hE4, 0, 1, 4'b0010, 1, 1, 12);
    add(0, 4'b0110, 8'hE4, 0, 1, 4'b0010, 1, 1, 13);
    add(0, 4'b0110, 8'hE4, 0, 1, 4'b0100, 2, 2, 14);
    // owner drops out, then reset mid-burst
    add(0, 4'b0010, 8'hE4, 0, 1, 4'b0010, 1, 1, 15);
    add(0, 4'b0010, 8'hE4, 0, 1, 4'b0010, 1, 1, 16);
    add(1, 4'b1111, 8'hE4, 0, 0, 4'b0000, 0, 0, 17);
    add(0, 4'b1111, 8'hE4, 0, 1, 4'b0001, 0, 0, 0);
    add(0, 4'b1111, 8'hE4, 0, 1, 4'b0001, 0, 0, 1);

    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].valid, tv[i].data, tv[i].full, 1'b0);
      chk("wr", i, 32'(bus.fifo_wr), 32'(tv[i].exp_wr));
      chk("ready", i, 32'(bus.req_ready), 32'(tv[i].exp_ready));
      chk("xfer_cnt", i, 32'(bus.xfer_cnt), 32'(tv[i].exp_xfer));
      if (tv[i].exp_wr) begin
        chk("grant_id", i, 32'(bus.grant_id), 32'(tv[i].exp_gid));
        chk("fifo_data", i, 32'(bus.fifo_data), 32'(tv[i].exp_dat));
      end
    end

    // ---- fill the fifo, hold while full, release one slot at a time ----
    model_en = 1'b1;
    drive(1, 4'b0000, 8'h00, 0, 0);
    for (int k = 0; k < 14; k++) begin
      drive(0, 4'b0010, 8'hE4, 0, 0);
      chk("fill_gid", k, 32'(bus.grant_id), 32'd1);
      chk("fill_wr", k, 32'(bus.fifo_wr), 32'd1);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 4'b0011, 8'hE4, 0, 0);
      chk("fill2_gid", k, 32'(bus.grant_id), 32'd0);
      chk("fill2_wr", k, 32'(bus.fifo_wr), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'b0011, 8'hE4, 0, 0);
      chk("full_flag", k, 32'(bus.fifo_full), 32'd1);
      chk("full_wr", k, 32'(bus.fifo_wr), 32'd0);
      chk("full_ready", k, 32'(bus.req_ready), 32'd0);
    end
    drive(0, 4'b0011, 8'hE4, 0, 1);
    chk("full_rd_wr", 0, 32'(bus.fifo_wr), 32'd0);
    drive(0, 4'b0011, 8'hE4, 0, 1);
    chk("resume_gid", 0, 32'(bus.grant_id), 32'd0);
    chk("resume_wr", 0, 32'(bus.req_ready), 32'b0001);
    chk("resume_xfer", 0, 32'(bus.xfer_cnt), 32'd16);
    drive(0, 4'b0011, 8'hE4, 0, 1);
    chk("resume_gid", 1, 32'(bus.grant_id), 32'd0);
    chk("resume_xfer", 1, 32'(bus.xfer_cnt), 32'd17);
    drive(0, 4'b0011, 8'hE4, 0, 1);
    chk("resume_gid", 2, 32'(bus.grant_id), 32'd1);
    chk("resume_dat", 2, 32'(bus.fifo_data), 32'd1);
    drive(0, 4'b0000, 8'h00, 0, 0);

    // ---- end to end: 4 producers x 16 random items ----
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 16; j++) pdata[i][j] = 2'($urandom_range(0, 3));
    drive(1, 4'b0000, 8'h00, 0, 0);
    e2e_en = 1'b1;
    drive(0, 4'b0000, 8'h00, 0, 0);
    cyc = 0;
    while (popped < 64 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("e2e_popped", cyc, 32'(popped), 32'd64);
    chk("e2e_xfer_cnt", 0, 32'(bus.xfer_cnt), 32'd64);
    chk("e2e_fifo_empty", 0, 32'(fq.size()), 32'd0);
    for (int i = 0; i < NR; i++) chk("e2e_consumed", i, 32'(pidx[i]), 32'd16);
    e2e_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
